// File: rtl/slurm32_cpu_pipeline_seq.sv
// SLURM32 instruction-pipeline sequencer: owns the PC, drives same-cycle fetch and shifts
// STAGES instruction/PC slots with branch flush, hazard stall, interrupt inject and halt.
module slurm32_cpu_pipeline_seq #(
    parameter int BITS = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int STAGES = 5,
    parameter int HAZARD_STAGE = 1,
    parameter int STALL_CYCLES = 3,
    parameter int FLUSH_STAGES = 2,
    parameter int IRQ_BITS = 4,
    parameter logic [BITS-1:0] NOP_INSTRUCTION = 32'h0,
    parameter logic [BITS-1:0] INT_INSTRUCTION = 32'h05000000,
    parameter logic [3:0] IMM_OPCODE = 4'h1
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    output logic                                  instruction_request,
    output logic [ADDRESS_BITS-1:0]               instruction_address,
    input  logic                                  instruction_valid,
    input  logic [BITS-1:0]                       instruction_in,
    output logic [STAGES*BITS-1:0]                pipeline_stages,
    output logic [STAGES*(ADDRESS_BITS-2)-1:0]    pc_stages,
    input  logic                                  load_pc_request,
    input  logic [ADDRESS_BITS-1:0]               load_pc_address,
    input  logic                                  hazard_request,
    input  logic                                  halt_request,
    input  logic                                  interrupt,
    input  logic [IRQ_BITS-1:0]                   irq,
    input  logic                                  interrupt_enable,
    input  logic                                  debugger_halt_request,
    input  logic                                  debugger_resume,
    input  logic                                  debugger_load_pc_request,
    input  logic [ADDRESS_BITS-1:0]               debugger_load_pc_address,
    output logic                                  halted,
    output logic [2:0]                            state
);
    localparam int PCW = ADDRESS_BITS - 2;
    localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_EXEC   = 3'd1,
        S_ISTALL = 3'd2,
        S_HSTALL = 3'd3,
        S_INTR   = 3'd4,
        S_IWAIT  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state_q;
    logic [PCW-1:0]   pc_q;
    logic [PCW-1:0]   prev_pc_q;
    logic [BITS-1:0]  slot_q    [STAGES];
    logic [PCW-1:0]   slot_pc_q [STAGES];
    logic [CNT_W-1:0] stall_cnt_q;
    logic             dbg_halt_q;

    logic            irq_take;
    logic            take_branch;
    logic [BITS-1:0] int_word;
    logic            unused_bits;

    // An IMM prefix and its operand must never be split by an injected interrupt.
    assign irq_take    = interrupt && interrupt_enable && (instruction_in[BITS-1 -: 4] != IMM_OPCODE);
    assign take_branch = load_pc_request &&
                         (state_q == S_EXEC || state_q == S_ISTALL || state_q == S_HSTALL);
    assign int_word    = INT_INSTRUCTION | {{(BITS-IRQ_BITS){1'b0}}, irq};
    assign unused_bits = ^{prev_pc_q, load_pc_address[1:0], debugger_load_pc_address[1:0]};

    assign instruction_request = (state_q == S_EXEC) || (state_q == S_ISTALL);
    assign instruction_address = {pc_q, 2'b00};
    assign halted              = (state_q == S_HALT);
    assign state               = state_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign pipeline_stages[g*BITS +: BITS] = slot_q[g];
        assign pc_stages[g*PCW +: PCW]         = slot_pc_q[g];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_RESET;
            pc_q        <= '0;
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
            dbg_halt_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                slot_q[k]    <= NOP_INSTRUCTION;
                slot_pc_q[k] <= '0;
            end
        end else begin
            if (state_q != S_RESET) begin
                for (int k = 1; k < STAGES; k++) begin
                    slot_q[k]    <= slot_q[k-1];
                    slot_pc_q[k] <= slot_pc_q[k-1];
                end
            end

            case (state_q)
                S_RESET: state_q <= S_EXEC;
                S_EXEC: begin
                    if (load_pc_request) begin
                        // branch handled after the case
                    end else if (irq_take) begin
                        state_q      <= S_INTR;
                        slot_q[0]    <= NOP_INSTRUCTION;
                        slot_pc_q[0] <= pc_q;
                    end else if (!instruction_valid) begin
                        state_q      <= S_ISTALL;
                        slot_q[0]    <= NOP_INSTRUCTION;
                        slot_pc_q[0] <= pc_q;
                    end else if (hazard_request) begin
                        state_q     <= S_HSTALL;
                        stall_cnt_q <= CNT_W'(STALL_CYCLES - 1);
                        for (int k = 0; k <= HAZARD_STAGE; k++) begin
                            slot_q[k]    <= slot_q[k];
                            slot_pc_q[k] <= slot_pc_q[k];
                        end
                        slot_q[HAZARD_STAGE+1]    <= NOP_INSTRUCTION;
                        slot_pc_q[HAZARD_STAGE+1] <= pc_q;
                    end else if (halt_request || debugger_halt_request) begin
                        state_q      <= S_HALT;
                        dbg_halt_q   <= debugger_halt_request;
                        slot_q[0]    <= NOP_INSTRUCTION;
                        slot_pc_q[0] <= pc_q;
                    end else begin
                        slot_q[0]    <= instruction_in;
                        slot_pc_q[0] <= pc_q;
                        prev_pc_q    <= pc_q;
                        pc_q         <= pc_q + PCW'(1);
                    end
                end
                S_ISTALL: begin
                    if (load_pc_request) begin
                        // branch handled after the case
                    end else if (instruction_valid) begin
                        state_q      <= S_EXEC;
                        slot_q[0]    <= instruction_in;
                        slot_pc_q[0] <= pc_q;
                        prev_pc_q    <= pc_q;
                        pc_q         <= pc_q + PCW'(1);
                    end else begin
                        slot_q[0]    <= NOP_INSTRUCTION;
                        slot_pc_q[0] <= pc_q;
                    end
                end
                S_HSTALL: begin
                    if (!load_pc_request) begin
                        for (int k = 0; k <= HAZARD_STAGE; k++) begin
                            slot_q[k]    <= slot_q[k];
                            slot_pc_q[k] <= slot_pc_q[k];
                        end
                        slot_q[HAZARD_STAGE+1]    <= NOP_INSTRUCTION;
                        slot_pc_q[HAZARD_STAGE+1] <= pc_q;
                        if (stall_cnt_q == '0) state_q <= S_EXEC;
                        else stall_cnt_q <= stall_cnt_q - CNT_W'(1);
                    end
                end
                S_INTR: begin
                    // Tagged with the held PC so the handler returns to the replayed word.
                    state_q      <= S_IWAIT;
                    slot_q[0]    <= int_word;
                    slot_pc_q[0] <= pc_q;
                end
                S_IWAIT: begin
                    slot_q[0]    <= NOP_INSTRUCTION;
                    slot_pc_q[0] <= pc_q;
                    if (!interrupt_enable) state_q <= S_EXEC;
                end
                S_HALT: begin
                    slot_q[0]    <= NOP_INSTRUCTION;
                    slot_pc_q[0] <= pc_q;
                    if (debugger_load_pc_request) begin
                        pc_q <= debugger_load_pc_address[ADDRESS_BITS-1:2];
                        for (int k = 0; k < STAGES; k++) begin
                            slot_q[k]    <= NOP_INSTRUCTION;
                            slot_pc_q[k] <= '0;
                        end
                    end
                    if (debugger_resume || (interrupt && !dbg_halt_q)) begin
                        state_q    <= S_EXEC;
                        dbg_halt_q <= 1'b0;
                    end
                end
                default: state_q <= S_RESET;
            endcase

            if (take_branch) begin
                state_q <= S_EXEC;
                pc_q    <= load_pc_address[ADDRESS_BITS-1:2];
                for (int k = 0; k < FLUSH_STAGES; k++) begin
                    slot_q[k]    <= NOP_INSTRUCTION;
                    slot_pc_q[k] <= pc_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_slurm32_cpu_pipeline_seq.sv
// Directed bench for slurm32_cpu_pipeline_seq; fetch memory returns 0x100 + word address.
module tb_slurm32_cpu_pipeline_seq;
    localparam int BITS = 32;
    localparam int PCW = 30;
    localparam int STAGES = 5;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic                     instruction_request;
    logic [31:0]              instruction_address;
    logic                     instruction_valid;
    logic [31:0]              instruction_in;
    logic [STAGES*BITS-1:0]   pipeline_stages;
    logic [STAGES*PCW-1:0]    pc_stages;
    logic                     load_pc_request;
    logic [31:0]              load_pc_address;
    logic                     hazard_request;
    logic                     halt_request;
    logic                     interrupt;
    logic [3:0]               irq;
    logic                     interrupt_enable;
    logic                     debugger_halt_request;
    logic                     debugger_resume;
    logic                     debugger_load_pc_request;
    logic [31:0]              debugger_load_pc_address;
    logic                     halted;
    logic [2:0]               state;

    logic        override_en;
    logic [31:0] override_word;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 CLK = ~CLK;

    assign instruction_in = override_en ? override_word
                                        : 32'h100 + {2'b00, instruction_address[31:2]};

    slurm32_cpu_pipeline_seq dut (
        .CLK(CLK), .RST(RST),
        .instruction_request(instruction_request), .instruction_address(instruction_address),
        .instruction_valid(instruction_valid), .instruction_in(instruction_in),
        .pipeline_stages(pipeline_stages), .pc_stages(pc_stages),
        .load_pc_request(load_pc_request), .load_pc_address(load_pc_address),
        .hazard_request(hazard_request), .halt_request(halt_request),
        .interrupt(interrupt), .irq(irq), .interrupt_enable(interrupt_enable),
        .debugger_halt_request(debugger_halt_request), .debugger_resume(debugger_resume),
        .debugger_load_pc_request(debugger_load_pc_request),
        .debugger_load_pc_address(debugger_load_pc_address),
        .halted(halted), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int k);
        return pipeline_stages[k*BITS +: BITS];
    endfunction

    function automatic logic [31:0] spc(input int k);
        return {2'b00, pc_stages[k*PCW +: PCW]};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        instruction_valid = 1'b1;
        load_pc_request = 1'b0; load_pc_address = '0;
        hazard_request = 1'b0; halt_request = 1'b0;
        interrupt = 1'b0; irq = 4'd5; interrupt_enable = 1'b0;
        debugger_halt_request = 1'b0; debugger_resume = 1'b0;
        debugger_load_pc_request = 1'b0; debugger_load_pc_address = '0;
        override_en = 1'b0; override_word = '0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_req", 32'(instruction_request), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", instruction_address, 32'd0);
        check("rst_slots_or", 32'(|pipeline_stages), 32'd0);
        RST = 1'b0;
        step();
        check("reset_to_exec", 32'(state), 32'd1);
        check("exec_req", 32'(instruction_request), 32'd1);

        // Sequential fetch
        for (int n = 0; n < 8; n++) begin
            check("seq_addr", instruction_address, 32'(4 * n));
            step();
            check("seq_slot0", slot(0), 32'h100 + 32'(n));
            check("seq_pc0", spc(0), 32'(n));
            if (n >= 4) check("seq_slot4", slot(4), 32'h100 + 32'(n - 4));
        end

        // Branch flush
        load_pc_request = 1'b1; load_pc_address = 32'h80;
        step();
        load_pc_request = 1'b0;
        check("br_addr", instruction_address, 32'h80);
        check("br_slot0", slot(0), 32'h0);
        check("br_slot1", slot(1), 32'h0);
        check("br_slot2", slot(2), 32'h106);
        check("br_state", 32'(state), 32'd1);
        step();
        step();
        check("br_fetch", slot(1), 32'h120);

        // Hazard stall
        hazard_request = 1'b1;
        step();
        hazard_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hz_state", 32'(state), 32'd3);
            check("hz_slot0", slot(0), 32'h121);
            check("hz_slot1", slot(1), 32'h120);
            check("hz_slot2", slot(2), 32'h0);
            check("hz_addr", instruction_address, 32'h88);
            step();
        end
        check("hz_exit", 32'(state), 32'd1);
        step();
        check("hz_resume0", slot(0), 32'h122);
        check("hz_resume1", slot(1), 32'h121);

        // Fetch miss at 0x10
        load_pc_request = 1'b1; load_pc_address = 32'h10;
        step();
        load_pc_request = 1'b0;
        instruction_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("miss_addr", instruction_address, 32'h10);
            step();
            check("miss_slot0", slot(0), 32'h0);
            check("miss_state", 32'(state), 32'd2);
        end
        instruction_valid = 1'b1;
        step();
        check("miss_cap", slot(0), 32'h104);
        check("miss_cap_pc", spc(0), 32'd4);
        check("miss_nop_once", slot(1), 32'h0);
        check("miss_exit", 32'(state), 32'd1);
        check("miss_next_addr", instruction_address, 32'h14);
        step();

        // Interrupt inject on word 0x106 (pc 6)
        interrupt = 1'b1; interrupt_enable = 1'b1;
        step();
        interrupt = 1'b0;
        check("int_state", 32'(state), 32'd4);
        check("int_slot0_nop", slot(0), 32'h0);
        check("int_addr_held", instruction_address, 32'h18);
        step();
        check("int_word", slot(0), 32'h05000005);
        check("int_word_pc", spc(0), 32'd6);
        check("iwait_state", 32'(state), 32'd5);
        step();
        check("iwait_nop", slot(0), 32'h0);
        check("iwait_shift", slot(1), 32'h05000005);
        step();
        check("iwait_once", slot(0), 32'h0);
        interrupt_enable = 1'b0;
        step();
        check("iwait_exit", 32'(state), 32'd1);
        step();
        check("int_replay", slot(0), 32'h106);
        check("int_replay_pc", spc(0), 32'd6);

        // IMM prefix defers the interrupt by one cycle
        interrupt = 1'b1; interrupt_enable = 1'b1;
        override_en = 1'b1; override_word = 32'h1234_5678;
        step();
        override_en = 1'b0;
        check("imm_state", 32'(state), 32'd1);
        check("imm_slot0", slot(0), 32'h1234_5678);
        step();
        interrupt = 1'b0;
        check("imm_intr", 32'(state), 32'd4);
        step();
        check("imm_int_word", slot(0), 32'h05000005);
        check("imm_int_pc", spc(0), 32'd8);
        interrupt_enable = 1'b0;
        step();
        step();
        check("imm_replay", slot(0), 32'h108);

        // Debugger halt, drain, PC load, resume
        debugger_halt_request = 1'b1;
        step();
        debugger_halt_request = 1'b0;
        check("dbg_halted", 32'(halted), 32'd1);
        check("dbg_state", 32'(state), 32'd6);
        check("dbg_req", 32'(instruction_request), 32'd0);
        repeat (STAGES) step();
        check("dbg_drained", 32'(|pipeline_stages), 32'd0);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        check("dbg_irq_no_exit", 32'(state), 32'd6);
        debugger_load_pc_request = 1'b1; debugger_load_pc_address = 32'h200;
        step();
        debugger_load_pc_request = 1'b0;
        check("dbg_pc_load", instruction_address, 32'h200);
        check("dbg_still_halt", 32'(halted), 32'd1);
        debugger_resume = 1'b1;
        step();
        debugger_resume = 1'b0;
        check("dbg_resume", 32'(state), 32'd1);
        step();
        check("dbg_fetch", slot(0), 32'h180);
        check("dbg_fetch_pc", spc(0), 32'h80);

        // SLEEP halt leaves on interrupt
        halt_request = 1'b1;
        step();
        halt_request = 1'b0;
        check("sleep_state", 32'(state), 32'd6);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        check("sleep_wake", 32'(state), 32'd1);

        // PC wrap
        load_pc_request = 1'b1; load_pc_address = 32'hFFFF_FFFF;
        step();
        load_pc_request = 1'b0;
        check("wrap_addr_hi", instruction_address, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", instruction_address, 32'h0);
        check("wrap_slot0", slot(0), 32'h4000_00FF);
        check("wrap_pc0", spc(0), 32'h3FFF_FFFF);

        // Asynchronous reset in the middle of a hazard stall
        hazard_request = 1'b1;
        step();
        hazard_request = 1'b0;
        check("mid_hstall", 32'(state), 32'd3);
        RST = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_addr", instruction_address, 32'h0);
        check("mid_rst_slots", 32'(|pipeline_stages), 32'd0);
        step();
        RST = 1'b0;
        step();
        check("post_rst_exec", 32'(state), 32'd1);
        step();
        check("post_rst_fetch", slot(0), 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
